// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus sequencer: state encoding, opcodes, bus source indices and
// instruction-register field positions.
package bus_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StDone,
    StAbort
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_SHR  = 5'h09;
  localparam logic [4:0] OP_SHRA = 5'h0A;
  localparam logic [4:0] OP_SHL  = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  // Bus source indices; R0..R15 occupy 0..15.
  localparam int unsigned SRC_R0     = 0;
  localparam int unsigned SRC_MDR    = 16;
  localparam int unsigned SRC_HI     = 17;
  localparam int unsigned SRC_LO     = 18;
  localparam int unsigned SRC_ZHIGH  = 19;
  localparam int unsigned SRC_ZLOW   = 20;
  localparam int unsigned SRC_PC     = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_C      = 23;

  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_MSB = 18;
  localparam int unsigned IR_RC_LSB = 15;

  typedef struct packed {
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic busy;
    logic done;
    logic err;
  } strobe_t;

endpackage

// File: rtl/bus_seq_decode.sv
// Opcode classifier: legality, multiply/divide (two-word result) and unary (single operand).
module bus_seq_decode
  import bus_ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output logic       legal_o,
  output logic       is_muldiv_o,
  output logic       is_unary_o
);

  always_comb begin
    legal_o     = 1'b0;
    is_muldiv_o = 1'b0;
    is_unary_o  = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        legal_o = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        legal_o     = 1'b1;
        is_muldiv_o = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        legal_o    = 1'b1;
        is_unary_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Moore control sequencer for the shared datapath bus: fetch plus R-format ALU execute.
// Outputs are decoded from the next state and registered, so they line up with state_q.
module bus_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 24,
  parameter int unsigned ALU_OP_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         IR,
  input  logic                mem_done,
  output logic [NUM_SRC-1:0]  bus_src_sel,
  output logic [15:0]         reg_in,
  output logic                PCin,
  output logic                IRin,
  output logic                MARin,
  output logic                MDRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  strobe_t             strobe_q, strobe_d;
  logic [NUM_SRC-1:0]  src_q, src_d;
  logic [15:0]         reg_in_q, reg_in_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       legal, is_muldiv, is_unary;
  logic       unused_ir;

  assign op = IR[IR_OP_MSB:IR_OP_LSB];
  assign ra = IR[IR_RA_MSB:IR_RA_LSB];
  assign rb = IR[IR_RB_MSB:IR_RB_LSB];
  assign rc = IR[IR_RC_MSB:IR_RC_LSB];
  assign unused_ir = ^IR[IR_RC_LSB-1:0];

  bus_seq_decode u_decode (
    .op_i        (op),
    .legal_o     (legal),
    .is_muldiv_o (is_muldiv),
    .is_unary_o  (is_unary)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0: begin
        state_d = StT1;
        cnt_d   = '0;
      end
      StT1: begin
        // mem_done on the final allowed cycle still wins over the timeout.
        if (mem_done) begin
          state_d = StT2;
        end else if (cnt_q == CntLast) begin
          state_d = StAbort;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StT2:    state_d = legal ? StT3 : StAbort;
      StT3:    state_d = StT4;
      StT4:    state_d = StT5;
      StT5:    state_d = is_muldiv ? StT6 : StDone;
      StT6:    state_d = StDone;
      StDone:  state_d = start ? StT0 : StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    logic       src_vld;
    logic [4:0] src_idx;
    strobe_d = '0;
    reg_in_d = '0;
    alu_op_d = '0;
    src_vld  = 1'b0;
    src_idx  = '0;
    strobe_d.busy = (state_d != StIdle);
    unique case (state_d)
      StT0: begin
        src_vld         = 1'b1;
        src_idx         = 5'(SRC_PC);
        strobe_d.mar_in = 1'b1;
        strobe_d.inc_pc = 1'b1;
        strobe_d.z_in   = 1'b1;
      end
      StT1: begin
        src_vld         = 1'b1;
        src_idx         = 5'(SRC_ZLOW);
        strobe_d.pc_in  = (state_q == StT0);
        strobe_d.read   = 1'b1;
        strobe_d.mdr_in = 1'b1;
      end
      StT2: begin
        src_vld        = 1'b1;
        src_idx        = 5'(SRC_MDR);
        strobe_d.ir_in = 1'b1;
      end
      StT3: begin
        src_vld       = 1'b1;
        src_idx       = 5'(SRC_R0) + {1'b0, rb};
        strobe_d.y_in = 1'b1;
      end
      StT4: begin
        src_vld       = 1'b1;
        src_idx       = 5'(SRC_R0) + {1'b0, (is_unary ? rb : rc)};
        strobe_d.z_in = 1'b1;
        alu_op_d      = ALU_OP_W'(op);
      end
      StT5: begin
        src_vld = 1'b1;
        src_idx = 5'(SRC_ZLOW);
        if (is_muldiv) strobe_d.lo_in = 1'b1;
        else           reg_in_d       = 16'(1) << ra;
      end
      StT6: begin
        src_vld        = 1'b1;
        src_idx        = 5'(SRC_ZHIGH);
        strobe_d.hi_in = 1'b1;
      end
      StDone:  strobe_d.done = 1'b1;
      StAbort: strobe_d.err  = 1'b1;
      default: ;
    endcase
    src_d = src_vld ? (NUM_SRC'(1) << src_idx) : '0;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      strobe_q <= '0;
      src_q    <= '0;
      reg_in_q <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      src_q    <= src_d;
      reg_in_q <= reg_in_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign bus_src_sel = src_q;
  assign reg_in      = reg_in_q;
  assign alu_op      = alu_op_q;
  assign PCin        = strobe_q.pc_in;
  assign IRin        = strobe_q.ir_in;
  assign MARin       = strobe_q.mar_in;
  assign MDRin       = strobe_q.mdr_in;
  assign Yin         = strobe_q.y_in;
  assign Zin         = strobe_q.z_in;
  assign HIin        = strobe_q.hi_in;
  assign LOin        = strobe_q.lo_in;
  assign IncPC       = strobe_q.inc_pc;
  assign Read        = strobe_q.read;
  assign busy        = strobe_q.busy;
  assign done        = strobe_q.done;
  assign err         = strobe_q.err;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench: a per-instruction transcript model of expected control words, compared
// every cycle against the sequencer outputs under directed and randomized instructions.
module tb_bus_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] IR;
  logic        mem_done;
  logic [23:0] bus_src_sel;
  logic [15:0] reg_in;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read, busy, done, err;
  logic [4:0]  alu_op;

  int checks = 0;
  int errors = 0;

  bus_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .IR          (IR),
    .mem_done    (mem_done),
    .bus_src_sel (bus_src_sel),
    .reg_in      (reg_in),
    .PCin        (PCin),
    .IRin        (IRin),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Yin         (Yin),
    .Zin         (Zin),
    .HIin        (HIin),
    .LOin        (LOin),
    .IncPC       (IncPC),
    .Read        (Read),
    .alu_op      (alu_op),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {src[23:0], reg_in[15:0], PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin, IncPC, Read, op, busy,done,err}
  logic [57:0] obs;
  assign obs = {bus_src_sel, reg_in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                IncPC, Read, alu_op, busy, done, err};

  typedef struct {
    logic [57:0] vec;
    logic        md;
    bit          last_instr;
    string       tag;
  } ent_t;

  ent_t q[$];

  function automatic logic [57:0] mk(int src, logic [15:0] rin, logic [7:0] lat, logic inc,
                                     logic rd, logic [4:0] op, logic bsy, logic dn, logic er);
    logic [23:0] s;
    s = (src < 0) ? 24'd0 : (24'd1 << src);
    return {s, rin, lat, inc, rd, op, bsy, dn, er};
  endfunction

  function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] ra, logic [3:0] rb,
                                        logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic bit is_legal(logic [4:0] op);
    return (op >= 5'h03 && op <= 5'h0B) || (op >= 5'h0F && op <= 5'h12);
  endfunction

  task automatic push(logic [57:0] v, logic md, bit last, string tag);
    ent_t e;
    e.vec = v;
    e.md = md;
    e.last_instr = last;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Appends the expected cycle-by-cycle transcript of one instruction.
  // wait_cyc < 0 means mem_done is never given.
  task automatic build(logic [31:0] ir, int wait_cyc, bit last);
    logic [4:0] op;
    int ra, rb, rc, n;
    bit muldiv, unary;
    op = ir[31:27];
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    muldiv = (op == 5'h0F) || (op == 5'h10);
    unary  = (op == 5'h11) || (op == 5'h12);
    push(mk(21, 0, 8'b0010_0100, 1, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T0");
    n = (wait_cyc < 0) ? 16 : wait_cyc + 1;
    for (int i = 0; i < n; i++) begin
      push(mk(20, 0, (i == 0) ? 8'b1001_0000 : 8'b0001_0000, 0, 1, 0, 1, 0, 0),
           (wait_cyc >= 0) && (i == wait_cyc), last, "T1");
    end
    if (wait_cyc < 0) begin
      push(mk(-1, 0, 0, 0, 0, 0, 1, 0, 1), 1'($urandom_range(0, 1)), last, "timeout_err");
      return;
    end
    push(mk(16, 0, 8'b0100_0000, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T2");
    if (!is_legal(op)) begin
      push(mk(-1, 0, 0, 0, 0, 0, 1, 0, 1), 1'($urandom_range(0, 1)), last, "illegal_err");
      return;
    end
    push(mk(rb, 0, 8'b0000_1000, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T3");
    push(mk(unary ? rb : rc, 0, 8'b0000_0100, 0, 0, op, 1, 0, 0), 1'($urandom_range(0, 1)),
         last, "T4");
    if (muldiv) begin
      push(mk(20, 0, 8'b0000_0001, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T5_lo");
      push(mk(19, 0, 8'b0000_0010, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T6_hi");
    end else begin
      push(mk(20, 16'd1 << ra, 0, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)), last, "T5_reg");
    end
    push(mk(-1, 0, 0, 0, 0, 0, 1, 1, 0), 1'($urandom_range(0, 1)), last, "done");
  endtask

  task automatic check(logic [57:0] expv, string tag);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  // Runs n back-to-back copies of one instruction from IDLE; clear_at >= 0 pulses clear right
  // after that transcript entry has been checked.
  task automatic run(logic [31:0] ir, int wait_cyc, int n, int clear_at);
    q.delete();
    for (int k = 0; k < n; k++) build(ir, wait_cyc, k == n - 1);
    push('0, 1'b0, 1'b1, "idle_after");
    IR = ir;
    start = 1'b1;
    mem_done = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock);
      check(q[i].vec, q[i].tag);
      if (q[i].last_instr) start = 1'b0;
      mem_done = q[i].md;
      if (i == clear_at) begin
        #1 clear = 1'b1;
        #1 check('0, "clear_async");
        @(negedge clock);
        check('0, "clear_held");
        clear = 1'b0;
        mem_done = 1'b0;
        return;
      end
    end
    mem_done = 1'b0;
  endtask

  initial begin
    logic [4:0] legal_ops [13];
    legal_ops = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
                  5'h0F, 5'h10, 5'h11, 5'h12};
    clear = 1'b1;
    start = 1'b0;
    IR = '0;
    mem_done = 1'b0;
    @(negedge clock);
    check('0, "reset");
    @(negedge clock);
    clear = 1'b0;
    check('0, "idle_no_start");

    // Clear during T4 of an ADD, then restart straight away.
    run(mk_ir(5'h03, 4'd5, 4'd2, 4'd3), 0, 1, 4);
    run(mk_ir(5'h03, 4'd5, 4'd2, 4'd3), 0, 1, -1);
    run(mk_ir(5'h0F, 4'd0, 4'd6, 4'd8), 0, 1, -1);
    run(mk_ir(5'h11, 4'd9, 4'd4, 4'd7), 2, 1, -1);
    run(mk_ir(5'h04, 4'd1, 4'd1, 4'd1), 5, 1, -1);
    run(mk_ir(5'h10, 4'd15, 4'd14, 4'd13), 15, 1, -1);
    run(mk_ir(5'h05, 4'd3, 4'd3, 4'd3), -1, 1, -1);
    run(mk_ir(5'h1F, 4'd3, 4'd4, 4'd5), 0, 1, -1);
    run(mk_ir(5'h00, 4'd3, 4'd4, 4'd5), 1, 1, -1);
    run(mk_ir(5'h03, 4'd7, 4'd8, 4'd9), 0, 3, -1);

    for (int t = 0; t < 24; t++) begin
      logic [4:0] op;
      op = (t % 6 == 5) ? 5'(5'h0C + $urandom_range(0, 2)) : legal_ops[$urandom_range(0, 12)];
      run(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)),
          $urandom_range(0, 6), is_legal(op) ? $urandom_range(1, 2) : 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
